// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: generates the fetch PC and buffers iCache words with their PCs
// in a DEPTH-entry FIFO towards decode (valid/ready), flushed on redirect.
module ifetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4,
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  iCacheReadAddr,
    input  logic [INSTR_W-1:0] iCacheReadData,
    input  logic               redirectEn,
    input  logic [ADDR_W-1:0]  redirectPC,
    output logic               instrValid,
    input  logic               instrReady,
    output logic [INSTR_W-1:0] instrOut,
    output logic [ADDR_W-1:0]  pcOut,
    output logic [CNT_W-1:0]   queueCount,
    output logic               queueFull
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic               not_empty_s;
    logic               not_full_s;
    logic               deq_s;
    logic               enq_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Handshake decode; a word may still be written at full when the head leaves the same cycle.
    always_comb begin
        not_empty_s = (count_q != CNT_W'(0));
        not_full_s  = (count_q < CNT_W'(DEPTH));
        deq_s       = not_empty_s & instrReady;
        enq_s       = ~redirectEn & (not_full_s | deq_s);
    end

    // Next-state: redirect flushes everything and discards any same-cycle handshake.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirectEn) begin
            fetch_pc_d = redirectPC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq_s) begin
                wr_ptr_d   = ptr_inc(wr_ptr_q);
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            end else begin
                wr_ptr_d   = wr_ptr_q;
                fetch_pc_d = fetch_pc_q;
            end
            if (deq_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && enq_s) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= iCacheReadData;
        end
    end

    // Outputs depend only on registered state; empty queue presents a NOP at PC 0.
    always_comb begin
        iCacheReadAddr = fetch_pc_q;
        instrValid     = not_empty_s;
        queueCount     = count_q;
        queueFull      = (count_q == CNT_W'(DEPTH));
        if (not_empty_s) begin
            instrOut = instr_mem_q[rd_ptr_q];
            pcOut    = pc_mem_q[rd_ptr_q];
        end else begin
            instrOut = '0;
            pcOut    = '0;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: default DUT (DEPTH=4) plus a DEPTH=3 DUT starting near PC wrap.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: defaults
    logic        a_rst, a_redir, a_ready;
    logic [31:0] a_redir_pc, a_addr, a_data, a_instr, a_pc;
    logic        a_valid, a_full;
    logic [2:0]  a_count;

    // DUT B: DEPTH=3, RESET_PC near the top of the address space
    logic        b_rst, b_redir, b_ready;
    logic [31:0] b_redir_pc, b_addr, b_data, b_instr, b_pc;
    logic        b_valid, b_full;
    logic [1:0]  b_count;

    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    assign a_data = a_addr ^ XMASK;
    assign b_data = b_addr ^ XMASK;

    ifetch_queue u_dut_a (
        .clk(clk), .rst(a_rst), .iCacheReadAddr(a_addr), .iCacheReadData(a_data),
        .redirectEn(a_redir), .redirectPC(a_redir_pc), .instrValid(a_valid),
        .instrReady(a_ready), .instrOut(a_instr), .pcOut(a_pc),
        .queueCount(a_count), .queueFull(a_full)
    );

    ifetch_queue #(.DEPTH(3), .RESET_PC(32'hFFFF_FFF8)) u_dut_b (
        .clk(clk), .rst(b_rst), .iCacheReadAddr(b_addr), .iCacheReadData(b_data),
        .redirectEn(b_redir), .redirectPC(b_redir_pc), .instrValid(b_valid),
        .instrReady(b_ready), .instrOut(b_instr), .pcOut(b_pc),
        .queueCount(b_count), .queueFull(b_full)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rst = 1'b1; a_redir = 1'b0; a_ready = 1'b0;
        tick();
        a_rst = 1'b0;
    endtask

    logic [31:0] exp_pc;
    int          n_del;

    initial begin
        a_rst = 1'b1; a_redir = 1'b0; a_redir_pc = 32'h0; a_ready = 1'b0;
        b_rst = 1'b1; b_redir = 1'b0; b_redir_pc = 32'h0; b_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check_val("rst_count", 32'(a_count), 32'd0);
        check_val("rst_valid", 32'(a_valid), 32'd0);
        check_val("rst_instr", a_instr, 32'h0);
        check_val("rst_pc",    a_pc,    32'h0);
        check_val("rst_full",  32'(a_full), 32'd0);
        check_val("rst_addr",  a_addr,  32'h0);

        // 1: streaming with ready high, one word per cycle after 1-cycle latency
        a_rst = 1'b0; a_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t1_valid", 32'(a_valid), 32'd1);
            check_val("t1_pc",    a_pc,    32'(i * 4));
            check_val("t1_instr", a_instr, 32'(i * 4) ^ XMASK);
            check_val("t1_count", 32'(a_count), 32'd1);
        end

        // 2: decode frozen fills the queue, fetch PC stalls at 16
        reset_a();
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_val("t2_fill", 32'(a_count), 32'(i));
        end
        tick();
        check_val("t2_full",  32'(a_full), 32'd1);
        check_val("t2_count", 32'(a_count), 32'd4);
        check_val("t2_addr",  a_addr, 32'd16);
        check_val("t2_head",  a_pc,   32'd0);

        // 3: one handshake at full: retire PC 0, write PC 16, fetch moves to 20
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check_val("t3_count", 32'(a_count), 32'd4);
        check_val("t3_head",  a_pc,   32'd4);
        check_val("t3_addr",  a_addr, 32'd20);
        a_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            check_val("t2_order", a_pc, 32'(i * 4));
            check_val("t2_instr", a_instr, 32'(i * 4) ^ XMASK);
        end

        // 4: redirect with 3 queued and head handshaking
        reset_a();
        tick(); tick(); tick();
        check_val("t4_pre", 32'(a_count), 32'd3);
        a_redir = 1'b1; a_redir_pc = 32'h100; a_ready = 1'b1;
        tick();
        a_redir = 1'b0;
        check_val("t4_count", 32'(a_count), 32'd0);
        check_val("t4_valid", 32'(a_valid), 32'd0);
        check_val("t4_instr", a_instr, 32'h0);
        check_val("t4_addr",  a_addr,  32'h100);
        tick();
        check_val("t4_pc",    a_pc,    32'h100);
        check_val("t4_instr2", a_instr, 32'h100 ^ XMASK);
        check_val("t4_count2", 32'(a_count), 32'd1);

        // Back-to-back redirects: last one wins
        a_redir = 1'b1; a_redir_pc = 32'h200;
        tick();
        check_val("b2b_addr1", a_addr, 32'h200);
        a_redir_pc = 32'h300;
        tick();
        a_redir = 1'b0;
        check_val("b2b_addr2",  a_addr, 32'h300);
        check_val("b2b_count",  32'(a_count), 32'd0);
        tick();
        check_val("b2b_pc", a_pc, 32'h300);

        // 5: reset beats a simultaneous redirect
        reset_a();
        tick(); tick(); tick();
        check_val("t5_pre", 32'(a_count), 32'd3);
        a_rst = 1'b1; a_redir = 1'b1; a_redir_pc = 32'h40; a_ready = 1'b1;
        tick();
        a_rst = 1'b0; a_redir = 1'b0;
        check_val("t5_count", 32'(a_count), 32'd0);
        check_val("t5_addr",  a_addr,  32'h0);
        check_val("t5_instr", a_instr, 32'h0);
        tick();
        check_val("t5_resume", a_pc, 32'h0);

        // 6: DEPTH=3 with random ready, in-order delivery across pointer and PC wrap
        b_rst = 1'b0;
        exp_pc = 32'hFFFF_FFF8;
        n_del  = 0;
        for (int c = 0; c < 50; c++) begin
            if (b_valid) begin
                check_val("t6_pc",    b_pc,    exp_pc);
                check_val("t6_instr", b_instr, exp_pc ^ XMASK);
            end
            b_ready = 1'($urandom_range(0, 1));
            if (b_valid && b_ready) begin
                exp_pc = exp_pc + 32'd4;
                n_del++;
            end
            tick();
        end
        check_val("t6_wrapped", 32'(n_del >= 3), 32'd1);
        b_ready = 1'b0;
        tick(); tick(); tick();
        check_val("t6_full",  32'(b_full),  32'd1);
        check_val("t6_count", 32'(b_count), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
